// File: rtl/barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shifter_pipe
//
// Pipelined logarithmic barrel shifter with valid/ready handshakes on both
// sides. Supports logical shifts, arithmetic right shift and rotates. An
// illegal opcode still travels the pipeline with normal latency, but it
// produces a zero result with out_err raised.
//
// Parameters
//   WIDTH   : data width, power of two, 8..128
//   LATENCY : 1 = single output register after the last layer
//             2 = extra register after layer SW/2-1
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operation offered
//   in_ready  : operation accepted when in_valid && in_ready
//   in_data   : operand
//   in_shamt  : shift amount, only bits [SW-1:0] are used
//   in_op     : 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
//   out_valid : result available
//   out_ready : result consumed when out_valid && out_ready
//   out_data  : result (zero for an illegal opcode)
//   out_zero  : out_data == 0
//   out_err   : illegal opcode
// -----------------------------------------------------------------------------
module barrel_shifter_pipe #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_shamt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);

    localparam int unsigned SW      = $clog2(WIDTH);
    localparam int unsigned WIDTH_U = WIDTH;
    // Index width able to address every shifter layer.
    localparam int unsigned KW      = (SW > 1) ? $clog2(SW) : 1;
    // Number of layers evaluated ahead of the middle register.
    localparam int unsigned SPLIT   = (LATENCY == 2) ? SW / 2 : 0;
    // Layer-enable masks: front section handles layers [0, SPLIT),
    // back section handles layers [SPLIT, SW).
    localparam logic [SW-1:0] LO_MASK = SW'((1 << SPLIT) - 1);
    localparam logic [SW-1:0] HI_MASK = ~LO_MASK;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_e;

    // Applies every layer whose bit is set in amt; layer k moves by 2^k.
    // Callers pre-mask amt so each pipeline section only runs its own layers.
    function automatic logic [WIDTH-1:0] shift_layers(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic [SW-1:0]    amt
    );
        logic [WIDTH-1:0] r;
        int unsigned      sh;
        r = d;
        for (int unsigned k = 0; k < SW; k++) begin
            sh = 32'd1 << k;
            if (amt[k[KW-1:0]]) begin
                case (op)
                    OP_SLL:  r = r << sh;
                    OP_SRL:  r = r >> sh;
                    OP_SRA:  r = $signed(r) >>> sh;
                    OP_ROL:  r = (r << sh) | (r >> (WIDTH_U - sh));
                    OP_ROR:  r = (r >> sh) | (r << (WIDTH_U - sh));
                    default: r = r;
                endcase
            end
        end
        return r;
    endfunction

    // Upper shift-amount bits are deliberately ignored.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^in_shamt[WIDTH-1:SW];

    // Operand as presented to the final (output) section.
    logic             fin_valid;
    logic [WIDTH-1:0] fin_data;
    logic [2:0]       fin_op;
    logic [SW-1:0]    fin_shamt;

    // Output register stage.
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_zero_q, out_zero_d;
    logic             out_err_q,  out_err_d;
    logic             out_adv;
    logic             accept;

    assign out_adv = !out_valid_q || out_ready;
    assign accept  = in_valid && in_ready;

    if (LATENCY == 2) begin : g_two_stage
        logic                s1_valid_q;
        logic [WIDTH-1:0]    s1_data_q, s1_data_d;
        logic [2:0]          s1_op_q;
        logic [SW-SPLIT-1:0] s1_shamt_q;
        logic                s1_adv;

        assign s1_adv   = !s1_valid_q || out_adv;
        // Reset forces in_ready low, so reset always wins over in_valid.
        assign in_ready = s1_adv && !rst;

        always_comb begin
            s1_data_d = shift_layers(in_data, in_op, in_shamt[SW-1:0] & LO_MASK);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
                s1_op_q    <= '0;
                s1_shamt_q <= '0;
            end else if (s1_adv) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_data_q  <= s1_data_d;
                    s1_op_q    <= in_op;
                    s1_shamt_q <= in_shamt[SW-1:SPLIT];
                end
            end
        end

        assign fin_valid = s1_valid_q;
        assign fin_data  = s1_data_q;
        assign fin_op    = s1_op_q;
        assign fin_shamt = {s1_shamt_q, {SPLIT{1'b0}}};
    end else begin : g_one_stage
        assign in_ready  = out_adv && !rst;
        assign fin_valid = accept;
        assign fin_data  = in_data;
        assign fin_op    = in_op;
        assign fin_shamt = in_shamt[SW-1:0];
    end

    // Result, zero and error flags are all formed ahead of the output register.
    always_comb begin
        out_err_d  = (fin_op > OP_ROR);
        out_data_d = '0;
        if (!out_err_d) begin
            out_data_d = shift_layers(fin_data, fin_op, fin_shamt & HI_MASK);
        end
        out_zero_d = (out_data_d == '0);
    end

    // Loaded only on advance, so outputs stay frozen under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (out_adv) begin
            out_valid_q <= fin_valid;
            if (fin_valid) begin
                out_data_q <= out_data_d;
                out_zero_q <= out_zero_d;
                out_err_q  <= out_err_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter_pipe
//
// Directed vectors with hand-computed results. The stimulus side pushes the
// expected response into a queue when an operation is accepted; a monitor
// pops and compares on every output transfer and checks that held outputs
// stay stable under backpressure.
// -----------------------------------------------------------------------------
module tb_barrel_shifter_pipe;

    localparam int WIDTH   = 64;
    localparam int LATENCY = 2;
    localparam int NVEC    = 18;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_shamt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_err;

    barrel_shifter_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] d;
        logic [63:0] sh;
        logic [63:0] e;
        logic        z;
        logic        er;
    } vec_t;

    typedef struct {
        logic [63:0] e;
        logic        z;
        logic        er;
    } exp_t;

    vec_t        vecs [NVEC];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void push(input vec_t v);
        exp_t x;
        x.e  = v.e;
        x.z  = v.z;
        x.er = v.er;
        exp_q.push_back(x);
    endfunction

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_op    = v.op;
        in_data  = v.d;
        in_shamt = v.sh;
    endtask

    // Offers one op, waits (bounded) for acceptance, returns at posedge+1.
    task automatic send(input vec_t v);
        int unsigned waited;
        bit          ok;
        waited = 0;
        ok     = 1'b0;
        drive(v);
        while (!ok) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                push(v);
            end else begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout actual=no_accept required=accept");
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check1("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: scoreboard compare on transfers, stability under stall.
    logic             hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_d;
    logic             hold_z;
    logic             hold_e;

    always @(negedge clk) begin
        exp_t x;
        if (hold_pend && out_valid) begin
            checks++;
            if (out_data !== hold_d || out_zero !== hold_z || out_err !== hold_e) begin
                errors++;
                $display("FAIL hold_stable actual=%h/%b/%b required=%h/%b/%b",
                         out_data, out_zero, out_err, hold_d, hold_z, hold_e);
            end
        end
        hold_pend = out_valid && !out_ready;
        hold_d    = out_data;
        hold_z    = out_zero;
        hold_e    = out_err;
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual=%h required=none", out_data);
            end else begin
                x = exp_q.pop_front();
                if (out_data !== x.e || out_zero !== x.z || out_err !== x.er) begin
                    errors++;
                    $display("FAIL result actual=%h z=%b e=%b required=%h z=%b e=%b",
                             out_data, out_zero, out_err, x.e, x.z, x.er);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned c0;
        int unsigned idx;
        int unsigned guard;

        //            op     data                   shamt    expected               z     err
        vecs[0]  = '{3'd2, 64'h8000_0000_0000_0000, 64'd63,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 64'h0123_4567_89AB_CDEF, 64'd64,  64'h0123_4567_89AB_CDEF, 1'b0, 1'b0};
        vecs[2]  = '{3'd0, 64'h0123_4567_89AB_CDEF, 64'd4,   64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0};
        vecs[3]  = '{3'd3, 64'h8000_0000_0000_0001, 64'd1,   64'h0000_0000_0000_0003, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 64'h8000_0000_0000_0001, 64'd1,   64'hC000_0000_0000_0000, 1'b0, 1'b0};
        vecs[5]  = '{3'd7, 64'h0000_0000_0000_00FF, 64'd0,   64'h0,                   1'b1, 1'b1};
        vecs[6]  = '{3'd0, 64'h0000_0000_0000_0001, 64'd63,  64'h8000_0000_0000_0000, 1'b0, 1'b0};
        vecs[7]  = '{3'd1, 64'h8000_0000_0000_0000, 64'd63,  64'h0000_0000_0000_0001, 1'b0, 1'b0};
        vecs[8]  = '{3'd0, 64'h0000_0000_0000_00FF, 64'd72,  64'h0000_0000_0000_FF00, 1'b0, 1'b0};
        vecs[9]  = '{3'd2, 64'h7000_0000_0000_0000, 64'd4,   64'h0700_0000_0000_0000, 1'b0, 1'b0};
        vecs[10] = '{3'd3, 64'h0123_4567_89AB_CDEF, 64'd16,  64'h4567_89AB_CDEF_0123, 1'b0, 1'b0};
        vecs[11] = '{3'd4, 64'h0123_4567_89AB_CDEF, 64'd8,   64'hEF01_2345_6789_ABCD, 1'b0, 1'b0};
        vecs[12] = '{3'd1, 64'h0000_0000_0000_000F, 64'd4,   64'h0,                   1'b1, 1'b0};
        vecs[13] = '{3'd2, 64'hF0F0_0000_0000_0000, 64'd8,   64'hFFF0_F000_0000_0000, 1'b0, 1'b0};
        vecs[14] = '{3'd4, 64'h0000_0000_0000_00A5, 64'd128, 64'h0000_0000_0000_00A5, 1'b0, 1'b0};
        vecs[15] = '{3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,   64'h0,                   1'b1, 1'b1};
        vecs[16] = '{3'd2, 64'h8000_0000_0000_0000, 64'd0,   64'h8000_0000_0000_0000, 1'b0, 1'b0};
        vecs[17] = '{3'd3, 64'hFEDC_BA98_7654_3210, 64'd36,  64'h6543_210F_EDCB_A987, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b1;

        // Reset state and in_ready behaviour around reset.
        @(negedge clk);
        check1("in_ready_during_rst", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check1("rst_out_valid", 64'(out_valid), 64'd0);
        check1("rst_out_data",  out_data,       64'd0);
        check1("rst_out_zero",  64'(out_zero),  64'd0);
        check1("rst_out_err",   64'(out_err),   64'd0);
        @(negedge clk);
        check1("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // First-result latency from acceptance.
        send(vecs[0]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check1("latency", 64'(n), 64'(LATENCY));
        drain();
        @(posedge clk);
        #1;

        // All vectors back to back at full rate.
        c0 = cyc;
        for (int i = 0; i < NVEC; i++) send(vecs[i]);
        check1("full_rate_cycles", 64'(cyc - c0), 64'(NVEC));
        drain();
        @(posedge clk);
        #1;

        // Backpressure: 4 ops offered, out_ready low for 5 cycles.
        out_ready = 1'b0;
        idx = 0;
        drive(vecs[10]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready) begin
                push(vecs[10 + idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 4) drive(vecs[10 + idx]);
            else in_valid = 1'b0;
        end
        check1("bp_accepted", 64'(idx), 64'd2);
        out_ready = 1'b1;
        c0    = cyc;
        guard = 0;
        while (idx < 4 && guard < 20) begin
            guard++;
            @(negedge clk);
            if (in_ready) begin
                push(vecs[10 + idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 4) drive(vecs[10 + idx]);
            else in_valid = 1'b0;
        end
        check1("bp_resume_cycles", 64'(cyc - c0), 64'd2);
        drain();
        @(posedge clk);
        #1;

        // Reset with two ops in flight; a simultaneous offer must be refused.
        out_ready = 1'b0;
        send(vecs[2]);
        send(vecs[3]);
        rst = 1'b1;
        drive(vecs[4]);
        @(negedge clk);
        check1("rst_priority_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check1("midrst_out_valid", 64'(out_valid), 64'd0);
        check1("midrst_out_data",  out_data,       64'd0);
        check1("midrst_out_zero",  64'(out_zero),  64'd0);
        check1("midrst_out_err",   64'(out_err),   64'd0);
        exp_q.delete();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check1("in_ready_after_midrst", 64'(in_ready), 64'd1);
        for (int c = 0; c < 6; c++) begin
            check1("flushed_no_output", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Pipeline still works after the flush.
        send(vecs[5]);
        send(vecs[17]);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
